// File: rtl/montgomery_precompute.sv
// Bit-serial Montgomery constant generator: finds R = 2^k > N, then R mod N,
// R^2 mod N (modular doubling) and n_prime = -N^-1 mod R (Hensel lifting), one bit per cycle.
module montgomery_precompute #(
    parameter  int DATA_WIDTH = 32,
    localparam int W          = DATA_WIDTH,
    localparam int KW         = $clog2(DATA_WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  modulant,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W:0]    r_val,
    output logic [W-1:0]  r_div_2,
    output logic [KW-1:0] k_bits,
    output logic [W-1:0]  r_mod,
    output logic [W-1:0]  r2_mod,
    output logic [W-1:0]  n_prime
);

    typedef enum logic [1:0] {S_IDLE, S_FIND_R, S_REDUCE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  n_q, n_d;
    logic [W:0]    rw_q, rw_d, x_q, x_d, t_q, t_d;
    logic [KW-1:0] kw_q, kw_d, i_q, i_d, cnt_q, cnt_d, k_q, k_d;
    logic          fin_q, fin_d, ferr_q, ferr_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [W:0]    r_val_q, r_val_d;
    logic [W-1:0]  rmod_q, rmod_d, r2_q, r2_d, np_q, np_d;

    logic [W:0]    n_ext_s, x2_s, x_red_s, t_sum_s, diff_s, diff2_s;

    assign n_ext_s = {1'b0, n_q};
    assign x2_s    = {x_q[W-1:0], 1'b0};
    assign x_red_s = (x2_s >= n_ext_s) ? (x2_s - n_ext_s) : x2_s;
    assign t_sum_s = t_q + n_ext_s;
    assign diff_s  = rw_q - n_ext_s;
    assign diff2_s = (diff_s >= n_ext_s) ? (diff_s - n_ext_s) : diff_s;

    // Completion is flagged internally first; done/err/busy follow one edge later.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        rw_d    = rw_q;
        kw_d    = kw_q;
        x_d     = x_q;
        t_d     = t_q;
        i_d     = i_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        ferr_d  = ferr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        r_val_d = r_val_q;
        k_d     = k_q;
        rmod_d  = rmod_q;
        r2_d    = r2_q;
        np_d    = np_q;
        if (start) begin
            n_d     = modulant;
            rw_d    = {{W{1'b0}}, 1'b1};
            kw_d    = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            r_val_d = '0;
            k_d     = '0;
            rmod_d  = '0;
            r2_d    = '0;
            np_d    = '0;
            if (modulant[0]) begin
                state_d = S_FIND_R;
                fin_d   = 1'b0;
                ferr_d  = 1'b0;
            end else begin
                state_d = S_IDLE;
                fin_d   = 1'b1;
                ferr_d  = 1'b1;
            end
        end else begin
            if (fin_q) begin
                fin_d  = 1'b0;
                done_d = 1'b1;
                err_d  = ferr_q;
                busy_d = 1'b0;
            end else begin
                fin_d  = 1'b0;
            end
            case (state_q)
                S_FIND_R: begin
                    if (rw_q <= n_ext_s) begin
                        rw_d = rw_q << 1;
                        kw_d = kw_q + KW'(1);
                    end else begin
                        r_val_d = rw_q;
                        k_d     = kw_q;
                        rmod_d  = diff2_s[W-1:0];
                        x_d     = diff2_s;
                        t_d     = {{W{1'b0}}, 1'b1};
                        i_d     = '0;
                        cnt_d   = kw_q;
                        state_d = S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    x_d = x_red_s;
                    // Odd remainder means this bit of n_prime is set; add N to clear bit 0.
                    if (t_q[0]) begin
                        np_d = np_q | ({{(W-1){1'b0}}, 1'b1} << i_q);
                        t_d  = t_sum_s >> 1;
                    end else begin
                        t_d  = t_q >> 1;
                    end
                    i_d   = i_q + KW'(1);
                    cnt_d = cnt_q - KW'(1);
                    if (cnt_q == KW'(1)) begin
                        r2_d    = x_red_s[W-1:0];
                        state_d = S_IDLE;
                        fin_d   = 1'b1;
                        ferr_d  = 1'b0;
                    end else begin
                        state_d = S_REDUCE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            rw_q    <= '0;
            kw_q    <= '0;
            x_q     <= '0;
            t_q     <= '0;
            i_q     <= '0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            r_val_q <= '0;
            k_q     <= '0;
            rmod_q  <= '0;
            r2_q    <= '0;
            np_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            rw_q    <= rw_d;
            kw_q    <= kw_d;
            x_q     <= x_d;
            t_q     <= t_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            r_val_q <= r_val_d;
            k_q     <= k_d;
            rmod_q  <= rmod_d;
            r2_q    <= r2_d;
            np_q    <= np_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign r_val   = r_val_q;
    assign r_div_2 = r_val_q[W:1];
    assign k_bits  = k_q;
    assign r_mod   = rmod_q;
    assign r2_mod  = r2_q;
    assign n_prime = np_q;

endmodule

// File: tb/tb_montgomery_precompute.sv
// Scoreboard bench for montgomery_precompute at W=8: expectations come from a
// plain-arithmetic reference model and are checked by a monitor on each rising done.
module tb_montgomery_precompute;
    localparam int W  = 8;
    localparam int KW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst, start;
    logic [W-1:0]  modulant;
    logic          busy, done, err;
    logic [W:0]    r_val;
    logic [W-1:0]  r_div_2, r_mod, r2_mod, n_prime;
    logic [KW-1:0] k_bits;

    montgomery_precompute #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .modulant(modulant),
        .busy(busy), .done(done), .err(err), .r_val(r_val), .r_div_2(r_div_2),
        .k_bits(k_bits), .r_mod(r_mod), .r2_mod(r2_mod), .n_prime(n_prime)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     n;
        bit     err;
        longint r_val;
        longint k;
        longint r_mod;
        longint r2;
        longint np;
        int     lat;
        int     t0;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int n, input int t0);
        exp_t   e;
        longint r;
        e.n = n; e.t0 = t0;
        e.err = 1'b0; e.r_val = 0; e.k = 0; e.r_mod = 0; e.r2 = 0; e.np = 0;
        if (n % 2 == 0) begin
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            while ((longint'(1) << e.k) <= n) e.k++;
            r       = longint'(1) << e.k;
            e.r_val = r;
            e.r_mod = r % n;
            e.r2    = (r * r) % n;
            for (longint c = 0; c < r; c++) begin
                if ((longint'(n) * c + 1) % r == 0) begin
                    e.np = c;
                    break;
                end
            end
            e.lat = 2 * int'(e.k) + 2;
        end
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: pops one expectation per rising done and compares every result field.
    always @(negedge clk) begin
        exp_t e;
        if (busy || done) check("busy_done_exclusive", longint'(busy & done), 0);
        if (done && !done_prev) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check($sformatf("err[N=%0d]", e.n), err, e.err);
                check($sformatf("r_val[N=%0d]", e.n), r_val, e.r_val);
                check($sformatf("r_div_2[N=%0d]", e.n), r_div_2, e.r_val >> 1);
                check($sformatf("k_bits[N=%0d]", e.n), k_bits, e.k);
                check($sformatf("r_mod[N=%0d]", e.n), r_mod, e.r_mod);
                check($sformatf("r2_mod[N=%0d]", e.n), r2_mod, e.r2);
                check($sformatf("n_prime[N=%0d]", e.n), n_prime, e.np);
                check($sformatf("latency[N=%0d]", e.n), cyc - e.t0, e.lat);
            end
        end
        done_prev <= done;
    end

    task automatic issue(input int n);
        @(posedge clk); #1;
        start    = 1'b1;
        modulant = W'(n);
        q.push_back(model(n, cyc + 1));
        @(posedge clk); #1;
        start    = 1'b0;
        modulant = W'($urandom);
        check($sformatf("busy_after_start[N=%0d]", n), busy, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending results expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_r_val"}, r_val, 0);
        check({tag, "_k_bits"}, k_bits, 0);
        check({tag, "_r_mod"}, r_mod, 0);
        check({tag, "_r2_mod"}, r2_mod, 0);
        check({tag, "_n_prime"}, n_prime, 0);
    endtask

    initial begin
        int dir_n[5];
        dir_n = '{13, 255, 1, 12, 0};
        rst = 1'b1; start = 1'b0; modulant = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_zero("reset");

        foreach (dir_n[j]) begin
            issue(dir_n[j]);
            wait_idle();
        end
        repeat (3) @(negedge clk);
        check("done_held", done, 1);

        // Abort a run of 13 with a restart on 11 two edges later.
        issue(13);
        @(posedge clk); #1;
        void'(q.pop_back());
        issue(11);
        wait_idle();

        // Reset in the middle of REDUCE, together with a start that must lose to it.
        issue(255);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1; start = 1'b1; modulant = W'(7);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check_zero("mid_reset");
        issue(13);
        wait_idle();

        for (int j = 0; j < 250; j++) begin
            issue(int'($urandom_range(0, 255)));
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
